cesa_pipe: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor. Generalises the fixed 32-bit, 4-bit-block carry-select adder.
- Operand width, select-block size and pipeline depth are parameters. An add/sub mode bit and a valid/ready handshake with back-pressure are added.
- Used in the execute stage wherever a wide add must be split across clock cycles to meet timing.

---
 rtl/cesa_pipe_if.sv | 38 +++
 rtl/cesa_pipe.sv | 157 +++++++++++++++
 tb/tb_cesa_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cesa_pipe_if.sv
// Operand/result handshake bundle for cesa_pipe.
// CESA_PIPE_FLAGS_EN adds the zero/overflow flag signals.
interface cesa_pipe_if #(
  parameter int WIDTH = 32
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             sub_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH:0]   sum_o;
`ifdef CESA_PIPE_FLAGS_EN
  logic             zero_o;
  logic             ovf_o;

  modport slave (
    input  in_valid_i, a_i, b_i, sub_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o, zero_o, ovf_o
  );

  modport master (
    output in_valid_i, a_i, b_i, sub_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o, zero_o, ovf_o
  );
`else
  modport slave (
    input  in_valid_i, a_i, b_i, sub_i, out_ready_i,
    output in_ready_o, out_valid_o, sum_o
  );

  modport master (
    output in_valid_i, a_i, b_i, sub_i, out_ready_i,
    input  in_ready_o, out_valid_o, sum_o
  );
`endif
endinterface

// File: rtl/cesa_pipe.sv
// Pipelined carry-select adder/subtractor: STAGES segments, one per register rank.
// Define CESA_PIPE_FLAGS_EN to add registered zero_o / ovf_o flags.
module cesa_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLK    = 4,
  parameter int STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  cesa_pipe_if.slave  bus
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int NBLK = SEG / BLK;

  if ((WIDTH % (BLK * STAGES)) != 0 || STAGES < 1 || STAGES > (WIDTH / BLK)) begin : g_bad_params
    $error("cesa_pipe: WIDTH must be divisible by BLK*STAGES and STAGES must be 1..WIDTH/BLK");
  end

  // One segment of carry-select: every block forms both sums, the ripple carry picks one.
  function automatic logic [SEG:0] csel(input logic [SEG-1:0] x, input logic [SEG-1:0] y,
                                        input logic cin);
    logic [SEG-1:0] s;
    logic           c;
    logic [BLK:0]   s0;
    logic [BLK:0]   s1;
    s = '0;
    c = cin;
    for (int k = 0; k < NBLK; k++) begin
      s0 = {1'b0, x[k*BLK +: BLK]} + {1'b0, y[k*BLK +: BLK]};
      s1 = {1'b0, x[k*BLK +: BLK]} + {1'b0, y[k*BLK +: BLK]} + {{BLK{1'b0}}, 1'b1};
      s[k*BLK +: BLK] = c ? s1[BLK-1:0] : s0[BLK-1:0];
      c = c ? s1[BLK] : s0[BLK];
    end
    return {c, s};
  endfunction

  logic             adv;
  logic [WIDTH-1:0] beff;

  assign beff           = bus.b_i ^ {WIDTH{bus.sub_i}};
  assign adv            = ~g_rank[STAGES-1].g_last.v | bus.out_ready_i;
  assign bus.in_ready_o = adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_rank
    localparam int LO = SEG * (s + 1);
    localparam int HI = WIDTH - LO;

    logic           vin;
    logic           ci;
    logic [SEG-1:0] sa;
    logic [SEG-1:0] sb;
    logic [SEG:0]   res;

    assign res = csel(sa, sb, ci);

    if (s == 0) begin : g_first
      assign vin = bus.in_valid_i;
      assign sa  = bus.a_i[SEG-1:0];
      assign sb  = beff[SEG-1:0];
      assign ci  = bus.sub_i;
    end else begin : g_next
      assign vin = g_rank[s-1].g_mid.v;
      assign sa  = g_rank[s-1].g_mid.ha[SEG-1:0];
      assign sb  = g_rank[s-1].g_mid.hb[SEG-1:0];
      assign ci  = g_rank[s-1].g_mid.c;
    end

    if (s < STAGES - 1) begin : g_mid
      logic          v;
      logic          c;
      logic [LO-1:0] lo;
      logic [HI-1:0] ha;
      logic [HI-1:0] hb;
      logic [LO-1:0] lo_d;
      logic [HI-1:0] ha_d;
      logic [HI-1:0] hb_d;

      if (s == 0) begin : g_d0
        assign lo_d = res[SEG-1:0];
        assign ha_d = bus.a_i[WIDTH-1:SEG];
        assign hb_d = beff[WIDTH-1:SEG];
      end else begin : g_dn
        assign lo_d = {res[SEG-1:0], g_rank[s-1].g_mid.lo};
        assign ha_d = g_rank[s-1].g_mid.ha[HI+SEG-1:SEG];
        assign hb_d = g_rank[s-1].g_mid.hb[HI+SEG-1:SEG];
      end

      // Intermediate rank: finished low bits, still-pending operand bits, segment carry.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v  <= 1'b0;
          c  <= 1'b0;
          lo <= '0;
          ha <= '0;
          hb <= '0;
        end else if (adv) begin
          v  <= vin;
          c  <= res[SEG];
          lo <= lo_d;
          ha <= ha_d;
          hb <= hb_d;
        end
      end
    end else begin : g_last
      logic             v;
      logic [WIDTH:0]   sum;
      logic [WIDTH-1:0] sum_d;

      if (s == 0) begin : g_d0
        assign sum_d = res[SEG-1:0];
      end else begin : g_dn
        assign sum_d = {res[SEG-1:0], g_rank[s-1].g_mid.lo};
      end

`ifdef CESA_PIPE_FLAGS_EN
      logic zero;
      logic ovf;
      logic cmsb;

      // The carry into the MSB falls out of the MSB sum bit and its operand bits.
      assign cmsb = res[SEG-1] ^ sa[SEG-1] ^ sb[SEG-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          zero <= 1'b0;
          ovf  <= 1'b0;
        end else if (adv && vin) begin
          zero <= (sum_d == '0);
          ovf  <= cmsb ^ res[SEG];
        end
      end
`endif

      // Output rank: data only moves on a real result so an idle output keeps its last value.
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          v   <= 1'b0;
          sum <= '0;
        end else if (adv) begin
          v <= vin;
          if (vin) begin
            sum <= {res[SEG], sum_d};
          end
        end
      end
    end
  end

  assign bus.out_valid_o = g_rank[STAGES-1].g_last.v;
  assign bus.sum_o       = g_rank[STAGES-1].g_last.sum;
`ifdef CESA_PIPE_FLAGS_EN
  assign bus.zero_o      = g_rank[STAGES-1].g_last.zero;
  assign bus.ovf_o       = g_rank[STAGES-1].g_last.ovf;
`endif

endmodule

// File: tb/tb_cesa_pipe.sv
// Scoreboard bench for cesa_pipe: main 32/4/2 instance plus (64,4,4), (16,8,1), (32,4,8) sweep instances.
module tb_cesa_pipe;

  typedef struct {
    logic [64:0] sum;
    int          cyc;
    logic        lat_chk;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        valid_drv;
  logic [63:0] a_drv;
  logic [63:0] b_drv;
  logic        sub_drv;
  logic        ready_main;
  logic        lat_main;
  logic        stream_chk;
  int          cycle = 0;
  int          tests = 0;
  int          failures = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  exp_t        q3[$];

  cesa_pipe_if #(.WIDTH(32)) bus0 ();
  cesa_pipe_if #(.WIDTH(64)) bus1 ();
  cesa_pipe_if #(.WIDTH(16)) bus2 ();
  cesa_pipe_if #(.WIDTH(32)) bus3 ();

  assign bus0.in_valid_i = valid_drv;
  assign bus0.a_i = a_drv[31:0];
  assign bus0.b_i = b_drv[31:0];
  assign bus0.sub_i = sub_drv;
  assign bus0.out_ready_i = ready_main;
  assign bus1.in_valid_i = valid_drv;
  assign bus1.a_i = a_drv;
  assign bus1.b_i = b_drv;
  assign bus1.sub_i = sub_drv;
  assign bus1.out_ready_i = 1'b1;
  assign bus2.in_valid_i = valid_drv;
  assign bus2.a_i = a_drv[15:0];
  assign bus2.b_i = b_drv[15:0];
  assign bus2.sub_i = sub_drv;
  assign bus2.out_ready_i = 1'b1;
  assign bus3.in_valid_i = valid_drv;
  assign bus3.a_i = a_drv[31:0];
  assign bus3.b_i = b_drv[31:0];
  assign bus3.sub_i = sub_drv;
  assign bus3.out_ready_i = 1'b1;

  cesa_pipe #(.WIDTH(32), .BLK(4), .STAGES(2)) dut0 (.clk_i(clock), .rst_ni(reset_n), .bus(bus0.slave));
  cesa_pipe #(.WIDTH(64), .BLK(4), .STAGES(4)) dut1 (.clk_i(clock), .rst_ni(reset_n), .bus(bus1.slave));
  cesa_pipe #(.WIDTH(16), .BLK(8), .STAGES(1)) dut2 (.clk_i(clock), .rst_ni(reset_n), .bus(bus2.slave));
  cesa_pipe #(.WIDTH(32), .BLK(4), .STAGES(8)) dut3 (.clk_i(clock), .rst_ni(reset_n), .bus(bus3.slave));

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  function automatic int width_of(input int d);
    case (d)
      0: return 32;
      1: return 64;
      2: return 16;
      default: return 32;
    endcase
  endfunction

  function automatic int stages_of(input int d);
    case (d)
      0: return 2;
      1: return 4;
      2: return 1;
      default: return 8;
    endcase
  endfunction

  function automatic logic out_valid_of(input int d);
    case (d)
      0: return bus0.out_valid_o;
      1: return bus1.out_valid_o;
      2: return bus2.out_valid_o;
      default: return bus3.out_valid_o;
    endcase
  endfunction

  function automatic logic in_ready_of(input int d);
    case (d)
      0: return bus0.in_ready_o;
      1: return bus1.in_ready_o;
      2: return bus2.in_ready_o;
      default: return bus3.in_ready_o;
    endcase
  endfunction

  function automatic logic [64:0] sum_of(input int d);
    case (d)
      0: return {32'd0, bus0.sum_o};
      1: return bus1.sum_o;
      2: return {48'd0, bus2.sum_o};
      default: return {32'd0, bus3.sum_o};
    endcase
  endfunction

  // Reference: (w+1)-bit result of a + (b or ~b) + sub, built with plain wide arithmetic.
  function automatic logic [64:0] model(input int w, input logic [63:0] a, input logic [63:0] b,
                                        input logic s);
    logic [65:0] m;
    logic [65:0] r;
    logic [63:0] be;
    m  = (66'd1 << w) - 66'd1;
    be = s ? ~b : b;
    r  = ({2'b0, a} & m) + ({2'b0, be} & m) + {65'd0, s};
    r  = r & ((66'd1 << (w + 1)) - 66'd1);
    return r[64:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [64:0] act, input logic [64:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic pushExpected(input int d);
    exp_t        e;
    logic [31:0] be;
    e.sum     = model(width_of(d), a_drv, b_drv, sub_drv);
    e.cyc     = cycle;
    e.lat_chk = (d == 0) ? lat_main : 1'b1;
    be        = sub_drv ? ~b_drv[31:0] : b_drv[31:0];
    e.zero    = (e.sum[31:0] == 32'd0);
    e.ovf     = (a_drv[31] == be[31]) && (e.sum[31] != a_drv[31]);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  task automatic popCompare(input int d);
    exp_t e;
    int   n;
    case (d)
      0: n = q0.size();
      1: n = q1.size();
      2: n = q2.size();
      default: n = q3.size();
    endcase
    if (n == 0) begin
      checkOutput($sformatf("d%0d unexpected valid", d), {64'd0, out_valid_of(d)}, 65'd0);
      return;
    end
    case (d)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      2: e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
    checkOutput($sformatf("d%0d sum", d), sum_of(d), e.sum);
    if (e.lat_chk)
      checkOutput($sformatf("d%0d latency", d), 65'(cycle - e.cyc), 65'(stages_of(d)));
`ifdef CESA_PIPE_FLAGS_EN
    if (d == 0) begin
      checkOutput("d0 zero", {64'd0, bus0.zero_o}, {64'd0, e.zero});
      checkOutput("d0 ovf", {64'd0, bus0.ovf_o}, {64'd0, e.ovf});
    end
`endif
  endtask

  // Monitor: inputs and outputs are stable at the falling edge, so handshakes are judged there.
  always @(negedge clock) begin
    if (reset_n) begin
      for (int d = 0; d < 4; d++) begin
        if (out_valid_of(d) && (d != 0 || ready_main)) popCompare(d);
        if (valid_drv && in_ready_of(d)) pushExpected(d);
      end
      if (stream_chk) checkOutput("stream in_ready", {64'd0, bus0.in_ready_o}, 65'd1);
    end
  end

  task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic s);
    int n;
    a_drv     = a;
    b_drv     = b;
    sub_drv   = s;
    valid_drv = 1'b1;
    n = 0;
    @(negedge clock);
    while (!bus0.in_ready_o && n < 200) begin
      n++;
      @(negedge clock);
    end
    if (n >= 200) checkOutput("accept timeout", {64'd0, bus0.in_ready_o}, 65'd1);
    @(posedge clock);
    #1;
    valid_drv = 1'b0;
  endtask

  task automatic runOne(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [64:0] exp_sum, input logic exp_zero, input logic exp_ovf);
    applyStimulus({32'd0, a}, {32'd0, b}, s);
    @(negedge clock);
    checkOutput("early valid", {64'd0, bus0.out_valid_o}, 65'd0);
    @(negedge clock);
    checkOutput("result valid", {64'd0, bus0.out_valid_o}, 65'd1);
    checkOutput("result sum", {32'd0, bus0.sum_o}, exp_sum);
`ifdef CESA_PIPE_FLAGS_EN
    checkOutput("result zero", {64'd0, bus0.zero_o}, {64'd0, exp_zero});
    checkOutput("result ovf", {64'd0, bus0.ovf_o}, {64'd0, exp_ovf});
`else
    if (exp_zero === 1'bx || exp_ovf === 1'bx) $display("[TB] note: unknown flag expectation");
`endif
    @(posedge clock);
    #1;
  endtask

  logic [63:0] pat_a[8];
  logic [63:0] pat_b[8];
  logic        pat_s[8];

  initial begin
    valid_drv  = 1'b0;
    a_drv      = '0;
    b_drv      = '0;
    sub_drv    = 1'b0;
    ready_main = 1'b1;
    lat_main   = 1'b1;
    stream_chk = 1'b0;
    reset_n    = 1'b0;

    #1;
    checkOutput("reset out_valid", {64'd0, bus0.out_valid_o}, 65'd0);
    checkOutput("reset sum", {32'd0, bus0.sum_o}, 65'd0);
    checkOutput("reset in_ready", {64'd0, bus0.in_ready_o}, 65'd1);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    runOne(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 65'h1_0000_0000, 1'b1, 1'b0);
    runOne(32'd5, 32'd7, 1'b1, 65'h0_FFFF_FFFE, 1'b0, 1'b0);
    runOne(32'h8000_0000, 32'd1, 1'b1, 65'h1_7FFF_FFFF, 1'b0, 1'b1);

    stream_chk = 1'b1;
    for (int i = 0; i < 100; i++)
      applyStimulus({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    stream_chk = 1'b0;
    repeat (10) @(posedge clock);
    #1;

    // Back-pressure: fill both ranks, stall five cycles, then drain.
    ready_main = 1'b0;
    lat_main   = 1'b0;
    applyStimulus(64'h1234_5678, 64'h1111_1111, 1'b0);
    applyStimulus(64'h0000_0010, 64'h0000_0020, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkOutput("stall in_ready", {64'd0, bus0.in_ready_o}, 65'd0);
      checkOutput("stall out_valid", {64'd0, bus0.out_valid_o}, 65'd1);
      checkOutput("stall sum", {32'd0, bus0.sum_o}, 65'h0_2345_6789);
    end
    @(posedge clock);
    #1;
    ready_main = 1'b1;
    @(negedge clock);
    checkOutput("drain first", {64'd0, bus0.out_valid_o}, 65'd1);
    @(negedge clock);
    checkOutput("drain second", {64'd0, bus0.out_valid_o}, 65'd1);
    @(negedge clock);
    checkOutput("drain empty", {64'd0, bus0.out_valid_o}, 65'd0);
    lat_main = 1'b1;
    @(posedge clock);
    #1;

    // Reset between edges with two transactions in flight.
    applyStimulus(64'h0000_0AAA, 64'h0000_0555, 1'b0);
    applyStimulus(64'h0000_0777, 64'h0000_0111, 1'b1);
    #2;
    checkOutput("pre-reset valid", {64'd0, bus0.out_valid_o}, 65'd1);
    reset_n = 1'b0;
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
    #1;
    checkOutput("mid reset valid", {64'd0, bus0.out_valid_o}, 65'd0);
    checkOutput("mid reset sum", {32'd0, bus0.sum_o}, 65'd0);
    checkOutput("mid reset in_ready", {64'd0, bus0.in_ready_o}, 65'd1);
    repeat (2) @(posedge clock);
    #3;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checkOutput("post-reset valid", {64'd0, bus0.out_valid_o}, 65'd0);
    end
    @(posedge clock);
    #1;

    // Carry-chain patterns applied to every instance, each at its own width.
    pat_a[0] = 64'hFFFF_FFFF_FFFF_FFFF; pat_b[0] = 64'h1;                   pat_s[0] = 1'b0;
    pat_a[1] = 64'hAAAA_AAAA_AAAA_AAAA; pat_b[1] = 64'h5555_5555_5555_5555; pat_s[1] = 1'b0;
    pat_a[2] = 64'hAAAA_AAAA_AAAA_AAAA; pat_b[2] = 64'h5555_5555_5555_5555; pat_s[2] = 1'b1;
    pat_a[3] = 64'h5555_5555_5555_5555; pat_b[3] = 64'hAAAA_AAAA_AAAA_AAAA; pat_s[3] = 1'b1;
    pat_a[4] = 64'h0;                   pat_b[4] = 64'h1;                   pat_s[4] = 1'b1;
    pat_a[5] = 64'hFFFF_FFFF_FFFF_FFFF; pat_b[5] = 64'hFFFF_FFFF_FFFF_FFFF; pat_s[5] = 1'b0;
    pat_a[6] = 64'h5555_5555_5555_5555; pat_b[6] = 64'h5555_5555_5555_5555; pat_s[6] = 1'b0;
    pat_a[7] = 64'h7FFF_FFFF_FFFF_FFFF; pat_b[7] = 64'h1;                   pat_s[7] = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(pat_a[i], pat_b[i], pat_s[i]);

    repeat (20) @(posedge clock);
    #1;
    checkOutput("d0 leftover", 65'(q0.size()), 65'd0);
    checkOutput("d1 leftover", 65'(q1.size()), 65'd0);
    checkOutput("d2 leftover", 65'(q2.size()), 65'd0);
    checkOutput("d3 leftover", 65'(q3.size()), 65'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
